// File: rtl/systolic_accelerator.sv
// Weight-stationary ARRAYHEIGHT x ARRAYWIDTH systolic matrix multiplier.
// Includes a skewed activation feed, a de-skewing output buffer and a ReLU / hard-max output stage.
module systolic_accelerator #(
    parameter int DATASIZE            = 8,
    parameter int ARRAYWIDTH          = 4,
    parameter int ARRAYHEIGHT         = 4,
    parameter int OUTPUT_BUF_DATASIZE = 32,
    parameter int DSP_DELAY           = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      weight_buffer_load_en,
    input  logic                                      weight_buffer_out_en,
    input  logic                                      write_weight_en,
    input  logic                                      input_buffer_load_en,
    input  logic                                      input_buffer_out_en,
    input  logic                                      output_buffer_load_en,
    input  logic                                      output_buffer_out_en,
    input  logic                                      relu_en,
    input  logic                                      softmax_en,
    input  logic [DATASIZE*ARRAYWIDTH-1:0]            in_act,
    input  logic [DATASIZE*ARRAYWIDTH-1:0]            in_weight,
    output logic [OUTPUT_BUF_DATASIZE*ARRAYWIDTH-1:0] out_top
);
    localparam int H       = ARRAYHEIGHT;
    localparam int W       = ARRAYWIDTH;
    localparam int OW      = OUTPUT_BUF_DATASIZE;
    localparam int RW      = W * DATASIZE;
    localparam int OROW    = W * OW;
    localparam int PW      = (H > 1) ? $clog2(H) : 1;
    localparam int CAP_LEN = DSP_DELAY * (H - 1) + H;
    localparam int CW      = $clog2(CAP_LEN + 1);

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(H - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [OROW-1:0] relu_row(input logic [OROW-1:0] row);
        logic [OROW-1:0] res;
        res = row;
        for (int c = 0; c < W; c++)
            if (row[c*OW + OW - 1]) res[c*OW +: OW] = '0;
        return res;
    endfunction

    // Strict '>' keeps the lowest index on ties.
    function automatic logic [OROW-1:0] hardmax_row(input logic [OROW-1:0] row);
        logic [OROW-1:0]      res;
        logic signed [OW-1:0] best;
        int                   best_idx;
        best     = $signed(row[OW-1:0]);
        best_idx = 0;
        for (int c = 1; c < W; c++) begin
            if ($signed(row[c*OW +: OW]) > best) begin
                best     = $signed(row[c*OW +: OW]);
                best_idx = c;
            end
        end
        for (int c = 0; c < W; c++)
            res[c*OW +: OW] = (c == best_idx) ? OW'(1) : '0;
        return res;
    endfunction

    logic [RW-1:0]              wbuf [H];
    logic [RW-1:0]              ibuf [H];
    logic [PW-1:0]              wb_wp, wb_rp, ib_wp, ib_rp;
    logic [RW-1:0]              wb_row, ib_row;
    logic signed [DATASIZE-1:0] pe_w   [H][W];
    logic signed [DATASIZE-1:0] act_h  [H][W];
    logic signed [OW-1:0]       psum_h [H][W];

    // Buffer reads are combinational on the read pointer, so same-row writes return old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < H; r++) begin
                wbuf[r] <= '0;
                ibuf[r] <= '0;
            end
            wb_wp <= '0;
            wb_rp <= '0;
            ib_wp <= '0;
            ib_rp <= '0;
        end else begin
            if (weight_buffer_load_en) begin
                wbuf[wb_wp] <= in_weight;
                wb_wp       <= ptr_next(wb_wp);
            end
            if (weight_buffer_out_en) wb_rp <= ptr_next(wb_rp);
            if (input_buffer_load_en) begin
                ibuf[ib_wp] <= in_act;
                ib_wp       <= ptr_next(ib_wp);
            end
            if (input_buffer_out_en) ib_rp <= ptr_next(ib_rp);
        end
    end

    assign wb_row = weight_buffer_out_en ? wbuf[wb_rp] : '0;
    assign ib_row = input_buffer_out_en  ? ibuf[ib_rp] : '0;

    // Weights enter at the top row (H-1) and shift down one row per strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) pe_w[r][c] <= '0;
        end else if (write_weight_en) begin
            for (int c = 0; c < W; c++) begin
                pe_w[H-1][c] <= $signed(wb_row[c*DATASIZE +: DATASIZE]);
                for (int r = 0; r < H - 1; r++) pe_w[r][c] <= pe_w[r+1][c];
            end
        end
    end

    // Skew stage: row r is delayed r*DSP_DELAY to meet the partial sum climbing the column.
    for (genvar r = 0; r < H; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign act_h[0][0] = $signed(ib_row[DATASIZE-1:0]);
        end else begin : g_delay
            logic signed [DATASIZE-1:0] skew_p [r*DSP_DELAY];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < r * DSP_DELAY; i++) skew_p[i] <= '0;
                end else begin
                    skew_p[0] <= $signed(ib_row[r*DATASIZE +: DATASIZE]);
                    for (int i = 1; i < r * DSP_DELAY; i++) skew_p[i] <= skew_p[i-1];
                end
            end
            assign act_h[r][0] = skew_p[r*DSP_DELAY-1];
        end
    end

    // PE stage: psum climbs from row 0 to row H-1; activations move right at the MAC latency.
    for (genvar r = 0; r < H; r++) begin : g_row
        for (genvar c = 0; c < W; c++) begin : g_col
            logic signed [OW-1:0] psum_in;
            logic signed [OW-1:0] sum_p [DSP_DELAY];
            if (r == 0) begin : g_base
                assign psum_in = '0;
            end else begin : g_chain
                assign psum_in = psum_h[r-1][c];
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DSP_DELAY; i++) sum_p[i] <= '0;
                end else begin
                    sum_p[0] <= psum_in + OW'(act_h[r][c]) * OW'(pe_w[r][c]);
                    for (int i = 1; i < DSP_DELAY; i++) sum_p[i] <= sum_p[i-1];
                end
            end
            assign psum_h[r][c] = sum_p[DSP_DELAY-1];

            if (c < W - 1) begin : g_pass
                logic signed [DATASIZE-1:0] act_p [DSP_DELAY];
                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int i = 0; i < DSP_DELAY; i++) act_p[i] <= '0;
                    end else begin
                        act_p[0] <= act_h[r][c];
                        for (int i = 1; i < DSP_DELAY; i++) act_p[i] <= act_p[i-1];
                    end
                end
                assign act_h[r][c+1] = act_p[DSP_DELAY-1];
            end
        end
    end

    logic [OROW-1:0] obuf [H];
    logic [CW-1:0]   cap_cnt;
    logic [W-1:0]    cap_hit;
    logic [PW-1:0]   cap_row [W];
    logic [PW-1:0]   ob_rp;
    logic [OROW-1:0] out_row_p0;

    // Column c sees row k on the (c*DSP_DELAY + k)-th cycle of the capture window.
    always_comb begin
        for (int c = 0; c < W; c++) begin
            cap_hit[c] = output_buffer_load_en
                       && (cap_cnt >= CW'(c * DSP_DELAY))
                       && (cap_cnt <  CW'(c * DSP_DELAY + H));
            cap_row[c] = PW'(cap_cnt - CW'(c * DSP_DELAY));
        end
    end

    // Output stage: de-skew capture, then row read into the held output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < H; r++) obuf[r] <= '0;
            cap_cnt    <= '0;
            ob_rp      <= '0;
            out_row_p0 <= '0;
        end else begin
            if (output_buffer_load_en) begin
                if (cap_cnt != CW'(CAP_LEN)) cap_cnt <= cap_cnt + CW'(1);
            end else begin
                cap_cnt <= '0;
            end
            for (int c = 0; c < W; c++)
                if (cap_hit[c]) obuf[cap_row[c]][c*OW +: OW] <= psum_h[H-1][c];
            if (output_buffer_out_en) begin
                out_row_p0 <= obuf[ob_rp];
                ob_rp      <= ptr_next(ob_rp);
            end
        end
    end

    always_comb begin
        if (softmax_en)   out_top = hardmax_row(out_row_p0);
        else if (relu_en) out_top = relu_row(out_row_p0);
        else              out_top = out_row_p0;
    end
endmodule

// File: tb/tb_systolic_accelerator.sv
// Directed bench for systolic_accelerator: runs DSP_DELAY=1 and DSP_DELAY=2 instances side by side.
// Both instances receive the same batches and must produce the same rows.
module tb_systolic_accelerator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         weight_buffer_load_en, weight_buffer_out_en, write_weight_en;
    logic         input_buffer_load_en, input_buffer_out_en;
    logic         olb1, olb2, output_buffer_out_en;
    logic         relu_en, softmax_en;
    logic [31:0]  in_act, in_weight;
    logic [127:0] out1, out2;

    systolic_accelerator #(.DSP_DELAY(1)) dut1 (
        .clk(clk), .rst(rst),
        .weight_buffer_load_en(weight_buffer_load_en), .weight_buffer_out_en(weight_buffer_out_en),
        .write_weight_en(write_weight_en), .input_buffer_load_en(input_buffer_load_en),
        .input_buffer_out_en(input_buffer_out_en), .output_buffer_load_en(olb1),
        .output_buffer_out_en(output_buffer_out_en), .relu_en(relu_en), .softmax_en(softmax_en),
        .in_act(in_act), .in_weight(in_weight), .out_top(out1)
    );

    systolic_accelerator #(.DSP_DELAY(2)) dut2 (
        .clk(clk), .rst(rst),
        .weight_buffer_load_en(weight_buffer_load_en), .weight_buffer_out_en(weight_buffer_out_en),
        .write_weight_en(write_weight_en), .input_buffer_load_en(input_buffer_load_en),
        .input_buffer_out_en(input_buffer_out_en), .output_buffer_load_en(olb2),
        .output_buffer_out_en(output_buffer_out_en), .relu_en(relu_en), .softmax_en(softmax_en),
        .in_act(in_act), .in_weight(in_weight), .out_top(out2)
    );

    typedef struct packed {
        logic [3:0][31:0]  w;
        logic [3:0][31:0]  a;
        logic              relu;
        logic              smax;
        logic [3:0][127:0] exp;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] r8(input int e0, input int e1, input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    function automatic logic [127:0] r32(input int e0, input int e1, input int e2, input int e3);
        return {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic idle_strobes();
        weight_buffer_load_en = 1'b0;
        weight_buffer_out_en  = 1'b0;
        write_weight_en       = 1'b0;
        input_buffer_load_en  = 1'b0;
        input_buffer_out_en   = 1'b0;
        olb1                  = 1'b0;
        olb2                  = 1'b0;
        output_buffer_out_en  = 1'b0;
        in_act                = '0;
        in_weight             = '0;
    endtask

    // Standard schedule: load 0-3, preload 4-7, stream 8-11, capture from 2H+D*W for D*(H-1)+H cycles.
    task automatic run_batch(input logic [3:0][31:0] w, input logic [3:0][31:0] a, input int abort_at);
        for (int t = 0; t < 28; t++) begin
            if (t == abort_at) break;
            weight_buffer_load_en = (t < 4);
            input_buffer_load_en  = (t < 4);
            in_weight             = (t < 4) ? w[2'(t)] : '0;
            in_act                = (t < 4) ? a[2'(t)] : '0;
            weight_buffer_out_en  = (t >= 4 && t < 8);
            write_weight_en       = (t >= 4 && t < 8);
            input_buffer_out_en   = (t >= 8 && t < 12);
            olb1                  = (t >= 12 && t < 19);
            olb2                  = (t >= 16 && t < 26);
            @(posedge clk); #1;
        end
        idle_strobes();
    endtask

    task automatic pop();
        output_buffer_out_en = 1'b1;
        @(posedge clk); #1;
        output_buffer_out_en = 1'b0;
    endtask

    vec_t             vecs [6];
    logic [3:0][31:0] id_w, ones_w, neg_w, id_a, ones_a, big_a, sm_a;
    logic [3:0][127:0] id_exp;

    initial begin
        id_w[0] = r8(1, 0, 0, 0);      id_w[1] = r8(0, 1, 0, 0);
        id_w[2] = r8(0, 0, 1, 0);      id_w[3] = r8(0, 0, 0, 1);
        for (int r = 0; r < 4; r++) begin
            ones_w[r] = r8(1, 1, 1, 1);
            neg_w[r]  = r8(-128, -128, -128, -128);
            big_a[r]  = r8(127, 127, 127, 127);
        end
        id_a[0]   = r8(1, 2, 3, 4);    id_a[1]   = r8(5, 6, 7, 8);
        id_a[2]   = r8(-1, -2, -3, -4); id_a[3]  = r8(0, 0, 0, 9);
        id_exp[0] = r32(1, 2, 3, 4);   id_exp[1] = r32(5, 6, 7, 8);
        id_exp[2] = r32(-1, -2, -3, -4); id_exp[3] = r32(0, 0, 0, 9);
        ones_a[0] = r8(1, 2, 3, 4);    ones_a[1] = r8(-1, -1, -1, -1);
        ones_a[2] = r8(0, 0, 0, 0);    ones_a[3] = r8(2, 0, 0, -5);
        sm_a[0]   = r8(3, 9, 9, 1);    sm_a[1]   = r8(-5, -2, -7, -2);
        sm_a[2]   = r8(4, 3, 2, 1);    sm_a[3]   = r8(0, 0, 0, 0);

        vecs[0] = '{w: id_w, a: id_a, relu: 1'b0, smax: 1'b0, exp: id_exp};
        vecs[1] = '{w: id_w, a: id_a, relu: 1'b1, smax: 1'b0,
                    exp: {r32(0, 0, 0, 9), r32(0, 0, 0, 0), r32(5, 6, 7, 8), r32(1, 2, 3, 4)}};
        vecs[2] = '{w: ones_w, a: ones_a, relu: 1'b0, smax: 1'b0,
                    exp: {r32(-3, -3, -3, -3), r32(0, 0, 0, 0), r32(-4, -4, -4, -4), r32(10, 10, 10, 10)}};
        vecs[3] = '{w: neg_w, a: big_a, relu: 1'b0, smax: 1'b0,
                    exp: {4{r32(-65024, -65024, -65024, -65024)}}};
        vecs[4] = '{w: neg_w, a: big_a, relu: 1'b1, smax: 1'b0, exp: '0};
        vecs[5] = '{w: id_w, a: sm_a, relu: 1'b1, smax: 1'b1,
                    exp: {r32(1, 0, 0, 0), r32(1, 0, 0, 0), r32(0, 1, 0, 0), r32(0, 1, 0, 0)}};

        idle_strobes();
        relu_en    = 1'b0;
        softmax_en = 1'b0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_top d1", out1, '0);
        check("reset out_top d2", out2, '0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pop();
            check($sformatf("reset obuf row%0d d1", k), out1, '0);
            check($sformatf("reset obuf row%0d d2", k), out2, '0);
        end

        for (int v = 0; v < 6; v++) begin
            run_batch(vecs[v].w, vecs[v].a, -1);
            relu_en    = vecs[v].relu;
            softmax_en = vecs[v].smax;
            for (int k = 0; k < 4; k++) begin
                pop();
                check($sformatf("vec%0d row%0d d1", v, k), out1, vecs[v].exp[k]);
                check($sformatf("vec%0d row%0d d2", v, k), out2, vecs[v].exp[k]);
            end
            relu_en    = 1'b0;
            softmax_en = 1'b0;
        end

        // out_top must hold while no pop is requested.
        run_batch(id_w, id_a, -1);
        pop();
        pop();
        repeat (3) @(posedge clk);
        #1;
        check("hold row1 d1", out1, id_exp[1]);
        check("hold row1 d2", out2, id_exp[1]);
        pop();
        pop();
        check("after hold row3 d1", out1, id_exp[3]);
        check("after hold row3 d2", out2, id_exp[3]);

        // Abort halfway through weight preload, then rerun the identity batch.
        run_batch(ones_w, big_a, 6);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset out_top d1", out1, '0);
        check("midreset out_top d2", out2, '0);
        rst = 1'b0;
        run_batch(id_w, id_a, -1);
        for (int k = 0; k < 4; k++) begin
            pop();
            check($sformatf("rerun row%0d d1", k), out1, id_exp[k]);
            check($sformatf("rerun row%0d d2", k), out2, id_exp[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
